i2c_slave: RTL and testbench

Synthesizable I2C target (responder) that answers the existing i2c master on the same SCL/SDA pair. It oversamples SCL/SDA on BUS_CLK, decodes START/STOP, address and data bytes, and exposes an 8-bit register-pointer interface to local FPGA logic. Standard I2C register protocol: the first written byte sets the pointer, later bytes write or read with auto-increment.

---
 rtl/i2c_slave_pkg.sv | 15 +
 rtl/i2c_slave_if.sv | 12 +
 rtl/i2c_slave_line_filter.sv | 65 ++++++
 rtl/i2c_slave.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_slave.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared encodings for the I2C target: FSM states and input synchronizer depth.
package i2c_slave_pkg;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_e;
endpackage

// File: rtl/i2c_slave_if.sv
// Register-pointer port between the I2C target and local logic.
interface i2c_slave_if;
  logic [7:0] REG_ADDR;
  logic [7:0] REG_WDATA;
  logic       REG_WR;
  logic       REG_RD;
  logic [7:0] REG_RDATA;
  logic       BUSY;

  modport slave  (output REG_ADDR, REG_WDATA, REG_WR, REG_RD, BUSY, input  REG_RDATA);
  modport master (input  REG_ADDR, REG_WDATA, REG_WR, REG_RD, BUSY, output REG_RDATA);
endinterface

// File: rtl/i2c_slave_line_filter.sv
// SCL/SDA synchronizers plus delay register; edge and START/STOP flags are
// registered so they line up with the delayed line values.
module i2c_line_filter
  import i2c_slave_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_DEPTH-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d;
  logic rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d;
  logic scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_DEPTH-1];
  assign sda_s = sda_sync_q[SYNC_DEPTH-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_DEPTH-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_DEPTH-2:0], sda_in};
    scl_dly_d  = scl_s;
    sda_dly_d  = sda_s;
    rise_d     = scl_s & ~scl_dly_q;
    fall_d     = ~scl_s & scl_dly_q;
    start_d    = scl_s & scl_dly_q & ~sda_s & sda_dly_q;
    stop_d     = scl_s & scl_dly_q & sda_s & ~sda_dly_q;
  end

  // Idle bus is high on both lines; reset there so no false edges appear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl       = scl_dly_q;
  assign sda       = sda_dly_q;
  assign scl_rise  = rise_q;
  assign scl_fall  = fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
endmodule

// File: rtl/i2c_slave.sv
// I2C target with an 8-bit auto-incrementing register pointer; first written
// byte after the address sets the pointer, later bytes write or read.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'b1001001,
  parameter int         HOLD_CYCLES = 2
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        I2C_SCL,
  inout  wire         I2C_SDA,
  i2c_slave_if.slave  reg_if
);
  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_filter u_filter (
    .clk      (BUS_CLK),
    .rst_n    (BUS_RST_N),
    .scl_in   (I2C_SCL),
    .sda_in   (I2C_SDA),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d, hold_cnt_q, hold_cnt_d;
  logic [7:0] shift_q, shift_d, addr_q, addr_d, wdata_q, wdata_d;
  logic       oe_q, oe_d, oe_pend_q, oe_pend_d;
  logic       wr_q, wr_d, rd_q, rd_d, cap_q, cap_d;
  logic       busy_q, busy_d, rw_q, rw_d, ptr_phase_q, ptr_phase_d;
  logic [7:0] byte_in;

  assign byte_in = {shift_q[6:0], sda};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    oe_d        = oe_q;
    oe_pend_d   = oe_pend_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    cap_d       = rd_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    ptr_phase_d = ptr_phase_q;

    // Read data arrives one cycle after the REG_RD pulse.
    if (cap_q) shift_d = reg_if.REG_RDATA;
    if (wr_q)  addr_d  = addr_q + 8'd1;

    // SDA only changes while SCL is low, HOLD_CYCLES after the fall.
    if (hold_cnt_q != 4'd0 && !scl) begin
      hold_cnt_d = hold_cnt_q - 4'd1;
      if (hold_cnt_q == 4'd1) oe_d = oe_pend_q;
    end

    if (start_det) begin
      state_d    = ST_ADDR;
      busy_d     = 1'b1;
      bit_cnt_d  = 4'd0;
      oe_d       = 1'b0;
      hold_cnt_d = 4'd0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      bit_cnt_d  = 4'd0;
      oe_d       = 1'b0;
      hold_cnt_d = 4'd0;
    end else if (scl_rise) begin
      unique case (state_q)
        ST_ADDR, ST_WDATA: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (state_q == ST_WDATA && bit_cnt_q == 4'd7) begin
            if (ptr_phase_q) begin
              addr_d      = byte_in;
              ptr_phase_d = 1'b0;
            end else begin
              wr_d    = 1'b1;
              wdata_d = byte_in;
            end
          end
        end
        ST_AACK: if (rw_q) rd_d = 1'b1;
        ST_RDATA: begin
          shift_d   = {shift_q[6:0], 1'b1};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        ST_RACK: begin
          bit_cnt_d = 4'd0;
          if (!sda) begin
            rd_d    = 1'b1;
            state_d = ST_RDATA;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      unique case (state_q)
        ST_ADDR: if (bit_cnt_q == 4'd8) begin
          bit_cnt_d  = 4'd0;
          hold_cnt_d = 4'(HOLD_CYCLES);
          if (shift_q[7:1] == ADDRESS) begin
            state_d   = ST_AACK;
            rw_d      = shift_q[0];
            oe_pend_d = 1'b1;
          end else begin
            state_d   = ST_IGNORE;
            oe_pend_d = 1'b0;
          end
        end
        ST_AACK: begin
          bit_cnt_d  = 4'd0;
          hold_cnt_d = 4'(HOLD_CYCLES);
          if (rw_q) begin
            state_d   = ST_RDATA;
            oe_pend_d = ~shift_q[7];
          end else begin
            state_d     = ST_WDATA;
            ptr_phase_d = 1'b1;
            oe_pend_d   = 1'b0;
          end
        end
        ST_WDATA: if (bit_cnt_q == 4'd8) begin
          state_d    = ST_WACK;
          bit_cnt_d  = 4'd0;
          oe_pend_d  = 1'b1;
          hold_cnt_d = 4'(HOLD_CYCLES);
        end
        ST_WACK: begin
          state_d    = ST_WDATA;
          oe_pend_d  = 1'b0;
          hold_cnt_d = 4'(HOLD_CYCLES);
        end
        ST_RDATA: begin
          hold_cnt_d = 4'(HOLD_CYCLES);
          if (bit_cnt_q == 4'd8) begin
            state_d   = ST_RACK;
            bit_cnt_d = 4'd0;
            addr_d    = addr_q + 8'd1;
            oe_pend_d = 1'b0;
          end else begin
            oe_pend_d = ~shift_q[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      hold_cnt_q  <= 4'd0;
      shift_q     <= 8'd0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      oe_q        <= 1'b0;
      oe_pend_q   <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cap_q       <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      ptr_phase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      oe_q        <= oe_d;
      oe_pend_q   <= oe_pend_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cap_q       <= cap_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      ptr_phase_q <= ptr_phase_d;
    end
  end

  assign I2C_SDA          = oe_q ? 1'b0 : 1'bz;
  assign reg_if.REG_ADDR  = addr_q;
  assign reg_if.REG_WDATA = wdata_q;
  assign reg_if.REG_WR    = wr_q;
  assign reg_if.REG_RD    = rd_q;
  assign reg_if.BUSY      = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master against i2c_slave with a register model and
// write/read scoreboards.
module tb_i2c_slave;
  localparam int Q = 5;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic scl;
  logic m_sda;
  wire  sda_line;

  pullup (sda_line);
  assign sda_line = m_sda ? 1'bz : 1'b0;

  i2c_slave_if reg_if ();

  i2c_slave #(.ADDRESS(7'b1001001), .HOLD_CYCLES(2)) dut (
    .BUS_CLK  (clk),
    .BUS_RST_N(rst_n),
    .I2C_SCL  (scl),
    .I2C_SDA  (sda_line),
    .reg_if   (reg_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, excl = 0, unexp = 0;
  wr_t        wr_exp[$];
  logic [7:0] rd_exp[$];
  logic [7:0] mem [256];
  logic [7:0] rdata = 8'd0;

  assign reg_if.REG_RDATA = rdata;

  always @(posedge clk) begin
    if (reg_if.REG_WR) mem[reg_if.REG_ADDR] <= reg_if.REG_WDATA;
    if (reg_if.REG_RD) rdata <= mem[reg_if.REG_ADDR];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_if.REG_WR && reg_if.REG_RD) excl++;
      if (reg_if.REG_RD) rd_cnt++;
      if (reg_if.REG_WR) begin
        wr_cnt++;
        if (wr_exp.size() == 0) unexp++;
        else begin
          wr_t e;
          e = wr_exp.pop_front();
          chk("wr_addr", 32'(reg_if.REG_ADDR), 32'(e.a));
          chk("wr_data", 32'(reg_if.REG_WDATA), 32'(e.d));
        end
      end
    end
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic drv, output logic smp);
    m_sda = drv; wq();
    scl = 1'b1;  wq();
    smp = (sda_line === 1'b0) ? 1'b0 : 1'b1;
    wq();
    scl = 1'b0;  wq();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq();
    scl = 1'b1;   wq();
    m_sda = 1'b0; wq();
    scl = 1'b0;   wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    scl = 1'b1;   wq();
    m_sda = 1'b1; wq(); wq();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d, output logic ackline);
    logic s;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clock_bit(nack, ackline);
  endtask

  task automatic wr_reg(input logic [7:0] d, input logic [7:0] a, input string tag);
    logic ack;
    wr_exp.push_back('{a: a, d: d});
    wbyte(d, ack);
    chk(tag, 32'(ack), 32'd0);
  endtask

  task automatic rd_check(input logic nack, input string tag);
    logic [7:0] d, e;
    logic       al;
    rbyte(nack, d, al);
    e = rd_exp.pop_front();
    chk(tag, 32'(d), 32'(e));
    if (nack) chk("nack_released", 32'(al), 32'd1);
  endtask

  initial begin
    logic ack;
    int   wr0, rd0;
    rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_addr",  32'(reg_if.REG_ADDR), 32'd0);
    chk("rst_wdata", 32'(reg_if.REG_WDATA), 32'd0);
    chk("rst_wr",    32'(reg_if.REG_WR), 32'd0);
    chk("rst_rd",    32'(reg_if.REG_RD), 32'd0);
    chk("rst_busy",  32'(reg_if.BUSY), 32'd0);
    chk("rst_sda",   32'(sda_line === 1'b0), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // register write: pointer 0x10, two data bytes
    i2c_start();
    chk("busy_start", 32'(reg_if.BUSY), 32'd1);
    wbyte(8'h92, ack); chk("w_addr_ack", 32'(ack), 32'd0);
    wbyte(8'h10, ack); chk("w_ptr_ack", 32'(ack), 32'd0);
    wr_reg(8'hA5, 8'h10, "w_d0_ack");
    wr_reg(8'h5A, 8'h11, "w_d1_ack");
    i2c_stop();
    chk("w_busy_stop", 32'(reg_if.BUSY), 32'd0);
    chk("w_final_ptr", 32'(reg_if.REG_ADDR), 32'h12);
    chk("w_wr_cnt", 32'(wr_cnt), 32'd2);

    // combined write pointer, repeated START, read two bytes
    rd0 = rd_cnt;
    i2c_start();
    wbyte(8'h92, ack); chk("c_addr_ack", 32'(ack), 32'd0);
    wbyte(8'h10, ack); chk("c_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    wbyte(8'h93, ack); chk("c_raddr_ack", 32'(ack), 32'd0);
    rd_exp.push_back(8'hA5);
    rd_exp.push_back(8'h5A);
    rd_check(1'b0, "c_rd0");
    rd_check(1'b1, "c_rd1");
    i2c_stop();
    chk("c_final_ptr", 32'(reg_if.REG_ADDR), 32'h12);
    chk("c_rd_cnt", 32'(rd_cnt - rd0), 32'd2);

    // address mismatch
    wr0 = wr_cnt; rd0 = rd_cnt;
    i2c_start();
    wbyte(8'h94, ack); chk("m_nack", 32'(ack), 32'd1);
    wbyte(8'h33, ack); chk("m_ignored", 32'(ack), 32'd1);
    chk("m_busy", 32'(reg_if.BUSY), 32'd1);
    i2c_stop();
    chk("m_busy_stop", 32'(reg_if.BUSY), 32'd0);
    chk("m_no_wr", 32'(wr_cnt - wr0), 32'd0);
    chk("m_no_rd", 32'(rd_cnt - rd0), 32'd0);

    // pointer wrap-around
    i2c_start();
    wbyte(8'h92, ack);
    wbyte(8'hFE, ack); chk("x_ptr_ack", 32'(ack), 32'd0);
    wr_reg(8'h11, 8'hFE, "x_d0_ack");
    wr_reg(8'h22, 8'hFF, "x_d1_ack");
    wr_reg(8'h33, 8'h00, "x_d2_ack");
    i2c_stop();
    chk("x_final_ptr", 32'(reg_if.REG_ADDR), 32'h01);

    // STOP after 4 bits of a data byte
    wr0 = wr_cnt;
    i2c_start();
    wbyte(8'h92, ack);
    wbyte(8'h20, ack);
    clock_bit(1'b1, ack); clock_bit(1'b1, ack);
    clock_bit(1'b0, ack); clock_bit(1'b0, ack);
    i2c_stop();
    chk("a_no_wr", 32'(wr_cnt - wr0), 32'd0);
    chk("a_ptr", 32'(reg_if.REG_ADDR), 32'h20);
    chk("a_busy", 32'(reg_if.BUSY), 32'd0);
    i2c_start();
    wbyte(8'h92, ack); chk("a_next_ack", 32'(ack), 32'd0);
    wbyte(8'h30, ack);
    wr_reg(8'h77, 8'h30, "a_next_d_ack");
    i2c_stop();
    chk("a_next_ptr", 32'(reg_if.REG_ADDR), 32'h31);

    // reset while the target drives a 0 data bit
    i2c_start();
    wbyte(8'h92, ack);
    wbyte(8'h40, ack);
    wr_reg(8'h00, 8'h40, "r_prep_ack");
    i2c_stop();
    i2c_start();
    wbyte(8'h92, ack);
    wbyte(8'h40, ack);
    i2c_start();
    wbyte(8'h93, ack); chk("r_raddr_ack", 32'(ack), 32'd0);
    m_sda = 1'b1; wq();
    scl = 1'b1; repeat (2) @(negedge clk);
    chk("r_driving0", 32'(sda_line === 1'b0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_sda_rel", 32'(sda_line === 1'b0), 32'd0);
    chk("r_addr", 32'(reg_if.REG_ADDR), 32'd0);
    chk("r_busy", 32'(reg_if.BUSY), 32'd0);
    chk("r_wr", 32'(reg_if.REG_WR), 32'd0);
    chk("r_rd", 32'(reg_if.REG_RD), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    chk("unexpected_wr", 32'(unexp), 32'd0);
    chk("wr_rd_overlap", 32'(excl), 32'd0);
    chk("wr_missing", 32'(wr_exp.size()), 32'd0);
    chk("rd_missing", 32'(rd_exp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
